// File: rtl/mem_block_arbiter_pkg.sv
// mem_arb_pkg: shared state, owner and op encodings plus default widths
// for the iCache/dCache backing-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int BLK_W_DEF    = 256;
    localparam int OFF_W_DEF    = 5;
    localparam int MAX_WAIT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arbState_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_block_arbiter_pick.sv
// mem_arb_pick: combinational winner/op selection for the memory arbiter.
// A requester with both rd and wr raised is serviced as a write first
// (writeback before refill). Between requesters dCache wins by default;
// with ARB_ROUND_ROBIN_EN defined, simultaneous requests go to whichever
// requester was not served last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic iRd,
    input  logic iWr,
    input  logic dRd,
    input  logic dWr,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic lastOwner,
`endif
    output logic valid,
    output logic winner,
    output logic op
);

    logic iWants;
    logic dWants;

    // Pick the winning requester, then its operation (write beats read).
    always_comb begin
        iWants = iRd | iWr;
        dWants = dRd | dWr;
        valid  = iWants | dWants;
        winner = OWN_I;
        if (iWants && dWants) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (lastOwner == OWN_D) ? OWN_I : OWN_D;
`else
            winner = OWN_D;
`endif
        end else if (dWants) begin
            winner = OWN_D;
        end
        if (winner == OWN_D) begin
            op = dWr ? OP_WR : OP_RD;
        end else begin
            op = iWr ? OP_WR : OP_RD;
        end
    end

endmodule

// File: rtl/mem_block_arbiter.sv
// mem_block_arbiter: shares one backing-memory block port between the
// iCache and dCache refill/writeback engines. One transaction at a time:
// IDLE grants, BUSY holds the strobe until mem_ready or timeout, DONE
// pulses the owner's ack. Optional ARB_ROUND_ROBIN_EN alternates winners
// on simultaneous requests instead of fixed dCache priority.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate pending requests
//   BUSY  | strobe held to memory, waiting for mem_ready
//   DONE  | owner's ack pulsed for one cycle, strobes low
module mem_block_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BLK_W    = BLK_W_DEF,
    parameter int OFF_W    = OFF_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_rd_req,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BLK_W-1:0]  i_wblock,
    output logic [BLK_W-1:0]  i_rblock,
    output logic              i_ack,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wblock,
    output logic [BLK_W-1:0]  d_rblock,
    output logic              d_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wblock,
    input  logic [BLK_W-1:0]  mem_rblock,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W - OFF_W){1'b0}}, {OFF_W{1'b1}}};

    logic [1:0]        state;
    logic              ownerReg;
    logic              opReg;
    logic [ADDR_W-1:0] addrReg;
    logic [BLK_W-1:0]  wblockReg;
    logic [BLK_W-1:0]  iRblockReg;
    logic [BLK_W-1:0]  dRblockReg;
    logic              timeoutReg;
    logic [CNT_W-1:0]  waitCnt;

    logic              pickValid;
    logic              pickWinner;
    logic              pickOp;
    logic [ADDR_W-1:0] grantAddr;
    logic [BLK_W-1:0]  grantWblock;

`ifdef ARB_ROUND_ROBIN_EN
    logic              lastOwner;
`endif

    mem_arb_pick uPick (
        .iRd       (i_rd_req),
        .iWr       (i_wr_req),
        .dRd       (d_rd_req),
        .dWr       (d_wr_req),
`ifdef ARB_ROUND_ROBIN_EN
        .lastOwner (lastOwner),
`endif
        .valid     (pickValid),
        .winner    (pickWinner),
        .op        (pickOp)
    );

    // Select the winner's block-aligned address and write data for latching.
    always_comb begin
        grantAddr   = ((pickWinner == OWN_D) ? d_addr : i_addr) & ~OFF_MASK;
        grantWblock = (pickWinner == OWN_D) ? d_wblock : i_wblock;
    end

    // Transaction FSM: grant, wait for memory or timeout, acknowledge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            ownerReg   <= OWN_I;
            opReg      <= OP_RD;
            addrReg    <= '0;
            wblockReg  <= '0;
            iRblockReg <= '0;
            dRblockReg <= '0;
            timeoutReg <= 1'b0;
            waitCnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastOwner  <= OWN_D;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pickValid) begin
                        state     <= ST_BUSY;
                        ownerReg  <= pickWinner;
                        opReg     <= pickOp;
                        addrReg   <= grantAddr;
                        wblockReg <= grantWblock;
                        waitCnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        if (opReg == OP_RD) begin
                            if (ownerReg == OWN_D) dRblockReg <= mem_rblock;
                            else                   iRblockReg <= mem_rblock;
                        end
                        state <= ST_DONE;
                    end else if (waitCnt == CNT_LAST) begin
                        // Timed-out reads hand back zeros rather than stale data.
                        timeoutReg <= 1'b1;
                        if (opReg == OP_RD) begin
                            if (ownerReg == OWN_D) dRblockReg <= '0;
                            else                   iRblockReg <= '0;
                        end
                        state <= ST_DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    lastOwner <= ownerReg;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from the registered transaction state.
    always_comb begin
        busy        = (state != ST_IDLE);
        mem_rd      = (state == ST_BUSY) && (opReg == OP_RD);
        mem_wr      = (state == ST_BUSY) && (opReg == OP_WR);
        mem_addr    = addrReg;
        mem_wblock  = wblockReg;
        owner       = ownerReg;
        timeout_err = timeoutReg;
        i_rblock    = iRblockReg;
        d_rblock    = dRblockReg;
        i_ack       = (state == ST_DONE) && (ownerReg == OWN_I);
        d_ack       = (state == ST_DONE) && (ownerReg == OWN_D);
    end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Testbench for mem_block_arbiter: directed scenarios plus randomized
// request mixes, checked against a transaction-level model of the
// arbitration rules, latency and timeout behaviour.
`timescale 1ns/1ps
module tb_mem_block_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int BLK_W    = 256;
    localparam int OFF_W    = 5;
    localparam int MAX_WAIT = 4;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              i_rd_req = 1'b0, i_wr_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [BLK_W-1:0]  i_wblock = '0;
    logic [BLK_W-1:0]  i_rblock;
    logic              i_ack;
    logic              d_rd_req = 1'b0, d_wr_req = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [BLK_W-1:0]  d_wblock = '0;
    logic [BLK_W-1:0]  d_rblock;
    logic              d_ack;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wblock;
    logic [BLK_W-1:0]  mem_rblock = '0;
    logic              mem_ready = 1'b0;
    logic              busy, owner, timeout_err;

    int errors = 0;
    int checks = 0;

    logic [BLK_W-1:0] expIRblock = '0;
    logic [BLK_W-1:0] expDRblock = '0;
    logic             expTimeout = 1'b0;
    logic             modelLast  = OWN_D;

    mem_block_arbiter #(
        .ADDR_W(ADDR_W), .BLK_W(BLK_W), .OFF_W(OFF_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_addr(i_addr),
        .i_wblock(i_wblock), .i_rblock(i_rblock), .i_ack(i_ack),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr),
        .d_wblock(d_wblock), .d_rblock(d_rblock), .d_ack(d_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wblock(mem_wblock), .mem_rblock(mem_rblock), .mem_ready(mem_ready),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] randBlk();
        logic [BLK_W-1:0] v;
        for (int k = 0; k < BLK_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One granted transaction, starting in an IDLE cycle with requests set.
    task automatic runTxn(input logic expOwner, input logic expOp,
                          input logic [ADDR_W-1:0] expAddr,
                          input logic [BLK_W-1:0] expW, input int latency);
        logic [BLK_W-1:0] data;
        int nBusy;
        data  = randBlk();
        nBusy = (latency <= MAX_WAIT) ? latency : MAX_WAIT;
        step();
        chk("busy_grant", busy, 1'b1);
        chk("owner", owner, expOwner);
        chk("mem_addr", mem_addr, expAddr);
        chk("mem_wblock", mem_wblock, expW);
        for (int c = 1; c <= nBusy; c++) begin
            chk("mem_rd_busy", mem_rd, expOp == OP_RD);
            chk("mem_wr_busy", mem_wr, expOp == OP_WR);
            chk("ack_in_busy", {i_ack, d_ack}, 2'b00);
            if (c == latency) begin
                mem_ready  = 1'b1;
                mem_rblock = data;
            end
            step();
            mem_ready  = 1'b0;
            mem_rblock = randBlk();
        end
        if (latency > MAX_WAIT) expTimeout = 1'b1;
        if (expOp == OP_RD) begin
            if (expOwner == OWN_D) expDRblock = (latency > MAX_WAIT) ? '0 : data;
            else                   expIRblock = (latency > MAX_WAIT) ? '0 : data;
        end
        chk("ack_done", {i_ack, d_ack}, (expOwner == OWN_D) ? 2'b01 : 2'b10);
        chk("strobes_done", {mem_rd, mem_wr}, 2'b00);
        chk("i_rblock", i_rblock, expIRblock);
        chk("d_rblock", d_rblock, expDRblock);
        chk("timeout_err", timeout_err, expTimeout);
        if (expOwner == OWN_D) begin
            if (expOp == OP_WR) d_wr_req = 1'b0; else d_rd_req = 1'b0;
        end else begin
            if (expOp == OP_WR) i_wr_req = 1'b0; else i_rd_req = 1'b0;
        end
        modelLast = expOwner;
        step();
        chk("busy_idle", busy, 1'b0);
        chk("ack_idle", {i_ack, d_ack}, 2'b00);
    endtask

    // Serve every pending request in the order the arbitration rules dictate.
    task automatic serveAll(input int fixedLat);
        logic iW, dW, win, op;
        logic [ADDR_W-1:0] a;
        for (int n = 0; n < 4 && (i_rd_req | i_wr_req | d_rd_req | d_wr_req); n++) begin
            iW = i_rd_req | i_wr_req;
            dW = d_rd_req | d_wr_req;
            if (iW && dW) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = (modelLast == OWN_D) ? OWN_I : OWN_D;
`else
                win = OWN_D;
`endif
            end else begin
                win = dW ? OWN_D : OWN_I;
            end
            if (win == OWN_D) op = d_wr_req ? OP_WR : OP_RD;
            else              op = i_wr_req ? OP_WR : OP_RD;
            a = ((win == OWN_D) ? d_addr : i_addr) / 32 * 32;
            runTxn(win, op, a, (win == OWN_D) ? d_wblock : i_wblock,
                   (fixedLat > 0) ? fixedLat : $urandom_range(1, 6));
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mem_rd, mem_wr}, 2'b00);
        chk("rst_acks", {i_ack, d_ack}, 2'b00);
        chk("rst_owner", owner, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_i_rblock", i_rblock, '0);
        chk("rst_d_rblock", d_rblock, '0);
        chk("rst_mem_addr", mem_addr, '0);
        RESET = 1'b0;
        step();

        // iCache read at 0x1234, mem_ready on the third BUSY cycle
        i_addr   = 32'h0000_1234;
        i_wblock = randBlk();
        i_rd_req = 1'b1;
        runTxn(OWN_I, OP_RD, 32'h0000_1220, i_wblock, 3);

        // dCache alone, then both reads together
        d_addr = 32'h0000_2008; d_wblock = randBlk(); d_rd_req = 1'b1;
        serveAll(2);
        i_addr = 32'h0000_3010; i_rd_req = 1'b1;
        d_addr = 32'h0000_4020; d_rd_req = 1'b1;
        serveAll(0);

        // dCache rd+wr together: write first, then read
        d_addr = 32'h0000_0040; d_wblock = randBlk();
        d_rd_req = 1'b1; d_wr_req = 1'b1;
        serveAll(1);

        // Timeout: mem_ready never arrives; flag stays set afterwards
        d_addr = 32'h0000_5000; d_rd_req = 1'b1;
        serveAll(MAX_WAIT + 3);
        i_addr = 32'h0000_6000; i_rd_req = 1'b1;
        serveAll(2);
        chk("timeout_sticky", timeout_err, 1'b1);

        // Back-to-back dCache requests
        d_addr = 32'h0000_7000; d_rd_req = 1'b1;
        serveAll(1);
        d_addr = 32'h0000_7100; d_rd_req = 1'b1;
        serveAll(1);

        // RESET during BUSY, stray mem_ready afterwards
        i_addr = 32'h0000_8000; i_rd_req = 1'b1;
        step();
        chk("pre_rst_mem_rd", mem_rd, 1'b1);
        RESET = 1'b1;
        step();
        RESET = 1'b0; i_rd_req = 1'b0;
        expIRblock = '0; expDRblock = '0; expTimeout = 1'b0; modelLast = OWN_D;
        chk("midrst_mem_rd", mem_rd, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_acks", {i_ack, d_ack}, 2'b00);
        chk("midrst_timeout", timeout_err, 1'b0);
        mem_ready = 1'b1; mem_rblock = randBlk();
        step();
        mem_ready = 1'b0;
        chk("stray_busy", busy, 1'b0);
        chk("stray_acks", {i_ack, d_ack}, 2'b00);
        chk("stray_i_rblock", i_rblock, expIRblock);
        step();
        chk("stray_acks2", {i_ack, d_ack}, 2'b00);

        // Randomized request mixes
        for (int r = 0; r < 30; r++) begin
            logic [3:0] bits;
            bits = 4'($urandom);
            if (bits == 4'b0) bits = 4'b0001;
            i_addr = $urandom; d_addr = $urandom;
            i_wblock = randBlk(); d_wblock = randBlk();
            {i_rd_req, i_wr_req, d_rd_req, d_wr_req} = bits;
            serveAll(0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
